// File: rtl/cache_repl_pkg.sv
// Shared definitions for the cache replacement policy block: width helper,
// policy encodings, flush FSM state type and LFSR constants.
package cache_repl_pkg;

    localparam int unsigned POLICY_LRU  = 0;
    localparam int unsigned POLICY_RAND = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } repl_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/repl_way_select.sv
// Combinational victim selector for one set: invalid-and-unlocked ways first,
// then oldest unlocked way (LRU) or first unlocked way from a start index (random).
module repl_way_select
    import cache_repl_pkg::*;
#(
    parameter  int unsigned WAYS_PER_SET = 4,
    parameter  int unsigned POLICY       = POLICY_LRU,
    localparam int unsigned WAYS_W       = clog2(WAYS_PER_SET)
) (
    input  logic [WAYS_PER_SET-1:0]             valid_mask_i,
    input  logic [WAYS_PER_SET-1:0]             lock_mask_i,
    input  logic [WAYS_PER_SET-1:0][WAYS_W-1:0] ages_i,
    input  logic [WAYS_W-1:0]                   start_i,
    output logic [WAYS_W-1:0]                   way_o,
    output logic                                none_o
);

    logic              found_inv;
    logic [WAYS_W-1:0] inv_way;
    logic              found_lru;
    logic [WAYS_W-1:0] lru_way;
    logic [WAYS_W-1:0] lru_age;
    logic              found_rnd;
    logic [WAYS_W-1:0] rnd_way;
    logic [WAYS_W-1:0] idx;

    always_comb begin
        found_inv = 1'b0;
        inv_way   = '0;
        found_lru = 1'b0;
        lru_way   = '0;
        lru_age   = '0;
        found_rnd = 1'b0;
        rnd_way   = '0;
        idx       = '0;

        for (int unsigned w = 0; w < WAYS_PER_SET; w++) begin
            if (!found_inv && !valid_mask_i[WAYS_W'(w)] && !lock_mask_i[WAYS_W'(w)]) begin
                found_inv = 1'b1;
                inv_way   = WAYS_W'(w);
            end
        end

        // Strict '>' keeps the lowest index on equal ages.
        for (int unsigned w = 0; w < WAYS_PER_SET; w++) begin
            if (!lock_mask_i[WAYS_W'(w)] && (!found_lru || ages_i[WAYS_W'(w)] > lru_age)) begin
                found_lru = 1'b1;
                lru_way   = WAYS_W'(w);
                lru_age   = ages_i[WAYS_W'(w)];
            end
        end

        // Way count is a power of two, so index arithmetic wraps naturally.
        for (int unsigned k = 0; k < WAYS_PER_SET; k++) begin
            idx = start_i + WAYS_W'(k);
            if (!found_rnd && !lock_mask_i[idx]) begin
                found_rnd = 1'b1;
                rnd_way   = idx;
            end
        end

        none_o = &lock_mask_i;
        if (none_o) begin
            way_o = '0;
        end else if (found_inv) begin
            way_o = inv_way;
        end else if (POLICY == POLICY_RAND) begin
            way_o = rnd_way;
        end else begin
            way_o = lru_way;
        end
    end

endmodule

// File: rtl/cache_repl_policy.sv
// Per-set victim selection with true-LRU age counters or LFSR pseudo-random
// choice, plus a one-set-per-cycle flush sweep that restores initial ages.
module cache_repl_policy
    import cache_repl_pkg::*;
#(
    parameter  int unsigned NUM_SET      = 4,
    parameter  int unsigned WAYS_PER_SET = 4,
    parameter  int unsigned POLICY       = POLICY_LRU,
    localparam int unsigned NUM_SET_W    = clog2(NUM_SET),
    localparam int unsigned WAYS_W       = clog2(WAYS_PER_SET)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    victim_req,
    input  logic [NUM_SET_W-1:0]    victim_set,
    input  logic [WAYS_PER_SET-1:0] victim_valid_mask,
    input  logic [WAYS_PER_SET-1:0] victim_lock_mask,
    output logic                    victim_rsp_valid,
    output logic [WAYS_W-1:0]       victim_way,
    output logic                    victim_none,
    input  logic                    update_req,
    input  logic [NUM_SET_W-1:0]    update_set,
    input  logic [WAYS_W-1:0]       update_way,
    input  logic                    flush_req,
    output logic                    busy
);

    repl_state_e                                       state_q;
    logic [NUM_SET_W-1:0]                              flush_ptr_q;
    logic                                              busy_q;
    logic                                              rsp_valid_q;
    logic [WAYS_W-1:0]                                 way_q;
    logic                                              none_q;
    logic [15:0]                                       lfsr_q;
    logic [15:0]                                       lfsr_d;
    logic [NUM_SET-1:0][WAYS_PER_SET-1:0][WAYS_W-1:0]  age_q;
    logic [NUM_SET-1:0][WAYS_PER_SET-1:0][WAYS_W-1:0]  age_d;

    logic              victim_accept;
    logic              update_accept;
    logic [WAYS_W-1:0] cur_age;
    logic [WAYS_W-1:0] sel_way;
    logic              sel_none;

    assign victim_accept = victim_req && (state_q == ST_IDLE) && !flush_req;
    assign update_accept = update_req && (state_q == ST_IDLE) && !flush_req
                           && (POLICY == POLICY_LRU);

    // Selection reads age_q, so a same-cycle update never affects the victim.
    repl_way_select #(
        .WAYS_PER_SET (WAYS_PER_SET),
        .POLICY       (POLICY)
    ) u_sel (
        .valid_mask_i (victim_valid_mask),
        .lock_mask_i  (victim_lock_mask),
        .ages_i       (age_q[victim_set]),
        .start_i      (lfsr_q[WAYS_W-1:0]),
        .way_o        (sel_way),
        .none_o       (sel_none)
    );

    always_comb begin
        lfsr_d  = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        age_d   = age_q;
        cur_age = age_q[update_set][update_way];
        if (state_q == ST_FLUSH) begin
            for (int unsigned w = 0; w < WAYS_PER_SET; w++) begin
                age_d[flush_ptr_q][WAYS_W'(w)] = WAYS_W'(w);
            end
        end else if (update_accept) begin
            for (int unsigned w = 0; w < WAYS_PER_SET; w++) begin
                if (age_q[update_set][WAYS_W'(w)] < cur_age) begin
                    age_d[update_set][WAYS_W'(w)] = age_q[update_set][WAYS_W'(w)] + WAYS_W'(1);
                end
            end
            age_d[update_set][update_way] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            flush_ptr_q <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            way_q       <= '0;
            none_q      <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            for (int unsigned s = 0; s < NUM_SET; s++) begin
                for (int unsigned w = 0; w < WAYS_PER_SET; w++) begin
                    age_q[NUM_SET_W'(s)][WAYS_W'(w)] <= WAYS_W'(w);
                end
            end
        end else begin
            lfsr_q      <= lfsr_d;
            age_q       <= age_d;
            rsp_valid_q <= victim_accept;
            if (victim_accept) begin
                way_q  <= sel_way;
                none_q <= sel_none;
            end
            case (state_q)
                ST_IDLE: begin
                    if (flush_req) begin
                        state_q     <= ST_FLUSH;
                        flush_ptr_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_ptr_q == NUM_SET_W'(NUM_SET - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        flush_ptr_q <= flush_ptr_q + NUM_SET_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign victim_rsp_valid = rsp_valid_q;
    assign victim_way       = way_q;
    assign victim_none      = none_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_cache_repl_policy.sv
// Directed bench for cache_repl_policy: an LRU instance and a random-policy
// instance share all inputs; expected values are hand-derived age tables.
module tb_cache_repl_policy;

    logic       clock;
    logic       reset;
    logic       victim_req;
    logic [1:0] victim_set;
    logic [3:0] victim_valid_mask;
    logic [3:0] victim_lock_mask;
    logic       update_req;
    logic [1:0] update_set;
    logic [1:0] update_way;
    logic       flush_req;

    logic       rsp_valid_l;
    logic [1:0] way_l;
    logic       none_l;
    logic       busy_l;
    logic       rsp_valid_r;
    logic [1:0] way_r;
    logic       none_r;
    logic       busy_r;

    int unsigned n_pass;
    int unsigned n_total;

    cache_repl_policy #(
        .NUM_SET      (4),
        .WAYS_PER_SET (4),
        .POLICY       (0)
    ) u_dut (
        .clock             (clock),
        .reset             (reset),
        .victim_req        (victim_req),
        .victim_set        (victim_set),
        .victim_valid_mask (victim_valid_mask),
        .victim_lock_mask  (victim_lock_mask),
        .victim_rsp_valid  (rsp_valid_l),
        .victim_way        (way_l),
        .victim_none       (none_l),
        .update_req        (update_req),
        .update_set        (update_set),
        .update_way        (update_way),
        .flush_req         (flush_req),
        .busy              (busy_l)
    );

    cache_repl_policy #(
        .NUM_SET      (4),
        .WAYS_PER_SET (4),
        .POLICY       (1)
    ) u_dut_rnd (
        .clock             (clock),
        .reset             (reset),
        .victim_req        (victim_req),
        .victim_set        (victim_set),
        .victim_valid_mask (victim_valid_mask),
        .victim_lock_mask  (victim_lock_mask),
        .victim_rsp_valid  (rsp_valid_r),
        .victim_way        (way_r),
        .victim_none       (none_r),
        .update_req        (update_req),
        .update_set        (update_set),
        .update_way        (update_way),
        .flush_req         (flush_req),
        .busy              (busy_r)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        victim_req        = 1'b0;
        victim_set        = 2'd0;
        victim_valid_mask = 4'b1111;
        victim_lock_mask  = 4'b0000;
        update_req        = 1'b0;
        update_set        = 2'd0;
        update_way        = 2'd0;
        flush_req         = 1'b0;
    endtask

    // One victim lookup on the LRU instance, checked one cycle later.
    task automatic lookup(input string name, input logic [1:0] set, input logic [3:0] vmask,
                          input logic [3:0] lmask, input logic [1:0] exp_way, input logic exp_none);
        victim_req        = 1'b1;
        victim_set        = set;
        victim_valid_mask = vmask;
        victim_lock_mask  = lmask;
        step();
        victim_req = 1'b0;
        n_total++;
        if ({rsp_valid_l, way_l, none_l} !== {1'b1, exp_way, exp_none}) begin
            $display("FAIL %s: valid/way/none = %0b/%0d/%0b, expected 1/%0d/%0b",
                     name, rsp_valid_l, way_l, none_l, exp_way, exp_none);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        n_total++;
        if ({rsp_valid_l, way_l, none_l, busy_l} !== 5'b0) begin
            $display("FAIL reset_outputs: valid/way/none/busy = %0b/%0d/%0b/%0b, expected 0/0/0/0",
                     rsp_valid_l, way_l, none_l, busy_l);
        end else begin
            n_pass++;
        end
        reset = 1'b1;
        step();
        n_total++;
        if (rsp_valid_l !== 1'b0) begin
            $display("FAIL no_spurious_rsp: valid = %0b, expected 0", rsp_valid_l);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_lru_reset_state();
        lookup("reset_ages_set2", 2'd2, 4'b1111, 4'b0000, 2'd3, 1'b0);
        step();
        n_total++;
        if (rsp_valid_l !== 1'b0) begin
            $display("FAIL rsp_one_cycle: valid = %0b, expected 0", rsp_valid_l);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_lru_update();
        logic [1:0] order [4];
        order = '{2'd3, 2'd2, 2'd1, 2'd0};
        update_req = 1'b1;
        update_set = 2'd1;
        foreach (order[i]) begin
            update_way = order[i];
            step();
        end
        update_req = 1'b0;
        // Ages set1 now {0,1,2,3}.
        lookup("lru_after_3210", 2'd1, 4'b1111, 4'b0000, 2'd3, 1'b0);
        update_req = 1'b1;
        update_set = 2'd1;
        update_way = 2'd3;
        step();
        update_req = 1'b0;
        // Ages set1 now {1,2,3,0}.
        lookup("lru_after_way3", 2'd1, 4'b1111, 4'b0000, 2'd2, 1'b0);
        lookup("other_set_untouched", 2'd2, 4'b1111, 4'b0000, 2'd3, 1'b0);
    endtask

    task automatic test_masks();
        lookup("invalid_priority", 2'd0, 4'b1011, 4'b0000, 2'd2, 1'b0);
        lookup("all_locked", 2'd0, 4'b1011, 4'b1111, 2'd0, 1'b1);
        lookup("lru_skips_locked", 2'd0, 4'b1111, 4'b1000, 2'd2, 1'b0);
        lookup("locked_invalid_ignored", 2'd0, 4'b1011, 4'b0100, 2'd3, 1'b0);
    endtask

    task automatic test_same_cycle();
        update_req = 1'b1;
        update_set = 2'd0;
        update_way = 2'd3;
        lookup("pre_update_ages", 2'd0, 4'b1111, 4'b0000, 2'd3, 1'b0);
        update_req = 1'b0;
        lookup("update_committed", 2'd0, 4'b1111, 4'b0000, 2'd2, 1'b0);
    endtask

    task automatic test_flush();
        logic [3:0] busy_seen;
        flush_req = 1'b1;
        step();
        busy_seen[0] = busy_l;
        // Lookup while busy, then a flush_req mid-sweep that must be ignored.
        flush_req         = 1'b0;
        victim_req        = 1'b1;
        victim_set        = 2'd1;
        victim_valid_mask = 4'b1111;
        victim_lock_mask  = 4'b0000;
        step();
        busy_seen[1] = busy_l;
        victim_req = 1'b0;
        n_total++;
        if (rsp_valid_l !== 1'b0) begin
            $display("FAIL no_rsp_while_busy: valid = %0b, expected 0", rsp_valid_l);
        end else begin
            n_pass++;
        end
        flush_req = 1'b1;
        step();
        busy_seen[2] = busy_l;
        flush_req = 1'b0;
        step();
        busy_seen[3] = busy_l;
        n_total++;
        if (busy_seen !== 4'b1111) begin
            $display("FAIL busy_during_flush: busy per cycle = %b, expected 1111", busy_seen);
        end else begin
            n_pass++;
        end
        step();
        n_total++;
        if ({busy_l, rsp_valid_l} !== 2'b00) begin
            $display("FAIL busy_drops_after_4: busy/valid = %0b/%0b, expected 0/0", busy_l, rsp_valid_l);
        end else begin
            n_pass++;
        end
        // Set1 was {1,2,3,0}; flushed back to {0,1,2,3}.
        lookup("ages_after_flush", 2'd1, 4'b1111, 4'b0000, 2'd3, 1'b0);
    endtask

    task automatic test_reset_mid_flush();
        update_req = 1'b1;
        update_set = 2'd3;
        update_way = 2'd3;
        step();
        update_req = 1'b0;
        // Set3 now {1,2,3,0}; flush_req outranks the simultaneous lookup.
        flush_req         = 1'b1;
        victim_req        = 1'b1;
        victim_set        = 2'd0;
        step();
        flush_req  = 1'b0;
        victim_req = 1'b0;
        n_total++;
        if ({busy_l, rsp_valid_l} !== 2'b10) begin
            $display("FAIL flush_priority: busy/valid = %0b/%0b, expected 1/0", busy_l, rsp_valid_l);
        end else begin
            n_pass++;
        end
        step();
        reset = 1'b0;
        step();
        n_total++;
        if ({busy_l, rsp_valid_l} !== 2'b00) begin
            $display("FAIL reset_aborts_flush: busy/valid = %0b/%0b, expected 0/0", busy_l, rsp_valid_l);
        end else begin
            n_pass++;
        end
        reset = 1'b1;
        step();
        n_total++;
        if (busy_l !== 1'b0) begin
            $display("FAIL busy_after_abort: busy = %0b, expected 0", busy_l);
        end else begin
            n_pass++;
        end
        lookup("ages_reset_mid_flush", 2'd3, 4'b1111, 4'b0000, 2'd3, 1'b0);
    endtask

    task automatic test_random();
        int unsigned bad;
        int unsigned cnt1;
        int unsigned cnt3;
        bad  = 0;
        cnt1 = 0;
        cnt3 = 0;
        victim_req        = 1'b1;
        victim_set        = 2'd0;
        victim_valid_mask = 4'b1111;
        victim_lock_mask  = 4'b0101;
        for (int i = 0; i < 64; i++) begin
            step();
            if (rsp_valid_r !== 1'b1 || none_r !== 1'b0) begin
                bad++;
            end else if (way_r == 2'd1) begin
                cnt1++;
            end else if (way_r == 2'd3) begin
                cnt3++;
            end else begin
                bad++;
            end
        end
        victim_req = 1'b0;
        n_total++;
        if (bad != 0) begin
            $display("FAIL rand_only_unlocked: %0d bad responses, expected 0", bad);
        end else begin
            n_pass++;
        end
        n_total++;
        if (cnt1 == 0 || cnt3 == 0) begin
            $display("FAIL rand_both_ways: way1=%0d way3=%0d, expected both nonzero", cnt1, cnt3);
        end else begin
            n_pass++;
        end
        victim_req        = 1'b1;
        victim_valid_mask = 4'b0111;
        victim_lock_mask  = 4'b0101;
        step();
        victim_req = 1'b0;
        n_total++;
        if ({rsp_valid_r, way_r, none_r} !== {1'b1, 2'd3, 1'b0}) begin
            $display("FAIL rand_invalid_priority: valid/way/none = %0b/%0d/%0b, expected 1/3/0",
                     rsp_valid_r, way_r, none_r);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        idle_inputs();
        test_reset();
        test_lru_reset_state();
        test_lru_update();
        test_masks();
        test_same_cycle();
        test_flush();
        test_reset_mid_flush();
        test_random();
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cache_repl_policy.md
CACHE_REPL_POLICY -- requirements
Module: cache_repl_policy

Interface
REQ-001 Parameter NUM_SET, default 4, number of sets; power of two, at least 2.
REQ-002 Parameter WAYS_PER_SET, default 4, ways per set; power of two, at least 2.
REQ-003 Parameter POLICY, default 0: 0 = true-LRU age counters, 1 = pseudo-random LFSR.
REQ-004 Derived widths: NUM_SET_W = clog2(NUM_SET); WAYS_W = clog2(WAYS_PER_SET).
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 victim_req  in  1  victim lookup request.
REQ-009 victim_set  in  NUM_SET_W  set being looked up.
REQ-010 victim_valid_mask  in  WAYS_PER_SET  valid bits of the looked-up set.
REQ-011 victim_lock_mask  in  WAYS_PER_SET  ways excluded from replacement.
REQ-012 victim_rsp_valid  out  1  response strobe, one cycle wide.
REQ-013 victim_way  out  WAYS_W  selected way.
REQ-014 victim_none  out  1  all ways locked; victim_way is 0.
REQ-015 update_req  in  1  access (hit or fill) notification.
REQ-016 update_set  in  NUM_SET_W  set being accessed.
REQ-017 update_way  in  WAYS_W  way being accessed.
REQ-018 flush_req  in  1  start re-initialisation of all sets.
REQ-019 busy  out  1  flush sweep is in progress.

Function
REQ-020 The victim response SHALL be registered: victim_rsp_valid is asserted exactly 1 cycle after an accepted victim_req.
REQ-021 Victim selection SHALL give invalid ways priority: the lowest-index way that is both invalid and unlocked.
REQ-022 When every way is valid and POLICY=0, the victim SHALL be the unlocked way with the largest age; ties are broken by the lowest index.
REQ-023 When every way is valid and POLICY=1, the search SHALL start at way lfsr[WAYS_W-1:0] and scan upward with wrap to the first unlocked way.
REQ-024 The LFSR SHALL be 16 bits, use polynomial x^16+x^14+x^13+x^11+1, and advance every cycle outside reset; its seed is 16'hACE1.
REQ-025 When all ways are locked, the block SHALL assert victim_none and drive victim_way = 0.
REQ-026 Age update: every way whose age is below age[update_way] SHALL increment, and update_way SHALL be set to 0. The ages remain a permutation of 0..WAYS_PER_SET-1, so the counters never overflow.
REQ-027 Age state SHALL only be updated when POLICY=0; when POLICY=1, update_req is ignored.
REQ-028 A victim_req and an update_req in the same cycle to the same set SHALL select from the pre-update ages; the update still commits.
REQ-029 Two-state FSM: IDLE and FLUSH. flush_req in IDLE moves to FLUSH with set pointer 0.
REQ-030 In FLUSH, one set per cycle SHALL have age[w] = w written. After set NUM_SET-1 the FSM returns to IDLE, so the flush takes NUM_SET cycles.
REQ-031 busy SHALL be high exactly while in FLUSH.
REQ-032 While busy, victim_req and update_req SHALL be ignored: no response and no state change.
REQ-033 flush_req asserted during FLUSH SHALL be ignored.
REQ-034 flush_req SHALL take priority over an update_req or victim_req presented in the same cycle.

Reset
REQ-035 On reset low: every age[w] = w in every set; FSM = IDLE; LFSR = seed.
REQ-036 On reset low: victim_rsp_valid = 0, victim_way = 0, victim_none = 0, busy = 0.
REQ-037 Reset asserted mid-flush SHALL abort the sweep and apply the full reset state on the next edge.

Structure
REQ-038 Package cache_repl_pkg SHALL hold the clog2 function, the policy encodings, the FSM state type and the LFSR seed and taps.
REQ-039 Sub-module repl_way_select SHALL be the combinational selector (valid and lock masks, ages or LFSR start index in; way and none out); it is instantiated once, on the muxed selected set.

Verification (NUM_SET=4, WAYS_PER_SET=4, POLICY=0 unless stated)
REQ-040 Scenario 1 -- after reset, victim_req set 2 with all ways valid -> next cycle victim_rsp_valid=1, victim_way=3.
REQ-041 Scenario 2 -- updates to set 1 for ways 3, 2, 1, 0, then victim_req set 1 with all valid -> victim_way=3. Then update way 3 and repeat the victim_req -> victim_way=2.
REQ-042 Scenario 3 -- victim_valid_mask=4'b1011, no locks -> victim_way=2. victim_lock_mask=4'b1111 -> victim_none=1, victim_way=0.
REQ-043 Scenario 4 -- victim_req and update_req (way 3) to set 0 in the same cycle, from reset state -> victim_way=3; the following victim_req -> victim_way=2.
REQ-044 Scenario 5 -- flush_req -> busy high for exactly 4 cycles and a victim_req during busy gets no response. Reset low at flush cycle 2 -> busy=0 and all ages reset.
REQ-045 Scenario 6 -- POLICY=1 with lock_mask=4'b0101 over 64 requests -> only ways 1 and 3 are returned and both occur.
